// File: rtl/addr_gen.sv
// addr_gen: address register with single-step, windowed wrap and auto-increment burst FSM
module addr_gen #(
  parameter int AW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] din,
  input  logic          arload,
  input  logic          arinc,
  input  logic          ardec,
  input  logic          wrap_en,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] limit,
  input  logic          burst_start,
  input  logic [LW-1:0] burst_len,
  input  logic          mem_ack,
  output logic [AW-1:0] dout,
  output logic          mem_req,
  output logic          burst_busy,
  output logic          burst_done,
  output logic          wrapped
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t        state, state_nxt;
  logic [LW-1:0] count, count_nxt;
  logic [AW-1:0] dout_nxt, inc_addr, dec_addr;
  logic          inc_win, dec_win, inc_wrap, dec_wrap;
  logic          mem_req_nxt, busy_nxt, done_nxt, wrapped_nxt;
  // neighbour addresses: window wrap at the bounds, otherwise modulo 2^AW
  always_comb begin
    inc_win  = wrap_en && dout == limit;
    dec_win  = wrap_en && dout == base;
    inc_addr = inc_win ? base : dout + 1'b1;
    dec_addr = dec_win ? limit : dout - 1'b1;
    inc_wrap = inc_win || &dout;
    dec_wrap = dec_win || ~|dout;
  end
  // next state and next registered outputs; arload overrides everything
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    dout_nxt    = dout;
    mem_req_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    wrapped_nxt = 1'b0;
    if (arload) begin
      dout_nxt  = din;
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE:
          if (burst_start && burst_len != '0) begin
            state_nxt   = BURST;
            count_nxt   = burst_len;
            mem_req_nxt = 1'b1;
            busy_nxt    = 1'b1;
          end else if (arinc ^ ardec) begin
            dout_nxt    = arinc ? inc_addr : dec_addr;
            wrapped_nxt = arinc ? inc_wrap : dec_wrap;
          end
        BURST: begin
          mem_req_nxt = 1'b1;
          busy_nxt    = 1'b1;
          if (mem_ack) begin
            dout_nxt    = inc_addr;
            wrapped_nxt = inc_wrap;
            count_nxt   = count - 1'b1;
            if (count == LW'(1)) begin
              state_nxt   = DONE;
              mem_req_nxt = 1'b0;
              busy_nxt    = 1'b0;
              done_nxt    = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      dout       <= '0;
      mem_req    <= 1'b0;
      burst_busy <= 1'b0;
      burst_done <= 1'b0;
      wrapped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      dout       <= dout_nxt;
      mem_req    <= mem_req_nxt;
      burst_busy <= busy_nxt;
      burst_done <= done_nxt;
      wrapped    <= wrapped_nxt;
    end
  end
endmodule

// File: tb/tb_addr_gen.sv
// tb_addr_gen: directed self-checking bench for addr_gen
module tb_addr_gen;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din, base, limit;
  logic        arload, arinc, ardec, wrap_en, burst_start, mem_ack;
  logic [7:0]  burst_len;
  logic [15:0] dout;
  logic        mem_req, burst_busy, burst_done, wrapped;
  logic [19:0] obs, e;
  int          checks = 0;
  int          errors = 0;

  assign obs = {dout, mem_req, burst_busy, burst_done, wrapped};

  addr_gen dut (
    .clk(clk), .rst(rst), .din(din), .arload(arload), .arinc(arinc), .ardec(ardec),
    .wrap_en(wrap_en), .base(base), .limit(limit), .burst_start(burst_start),
    .burst_len(burst_len), .mem_ack(mem_ack), .dout(dout), .mem_req(mem_req),
    .burst_busy(burst_busy), .burst_done(burst_done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a);
    arload = 1'b1;
    din = a;
    tick();
    arload = 1'b0;
  endtask

  task automatic test_reset();
    e = {16'h0000, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL reset_state got %h exp %h", obs, e); end
  endtask

  task automatic test_async_reset();
    load(16'h1234);
    e = {16'h1234, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL rst_preload got %h exp %h", obs, e); end
    burst_start = 1'b1; burst_len = 8'd4;
    tick();
    burst_start = 1'b0;
    e = {16'h1234, 4'b1100};
    checks++; if (obs !== e) begin errors++; $display("FAIL rst_burst_on got %h exp %h", obs, e); end
    #2 rst = 1'b1;
    #1;
    e = {16'h0000, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL rst_async got %h exp %h", obs, e); end
    #1 rst = 1'b0;
    tick();
    checks++; if (obs !== e) begin errors++; $display("FAIL rst_after1 got %h exp %h", obs, e); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (obs !== e) begin errors++; $display("FAIL rst_idle_ack got %h exp %h", obs, e); end
  endtask

  task automatic test_inc_dec();
    wrap_en = 1'b0;
    load(16'h00FF);
    e = {16'h00FF, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL inc_load got %h exp %h", obs, e); end
    arinc = 1'b1;
    tick();
    e = {16'h0100, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL inc_1 got %h exp %h", obs, e); end
    tick();
    e = {16'h0101, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL inc_2 got %h exp %h", obs, e); end
    ardec = 1'b1;
    tick();
    checks++; if (obs !== e) begin errors++; $display("FAIL inc_dec_hold got %h exp %h", obs, e); end
    arinc = 1'b0;
    tick();
    ardec = 1'b0;
    e = {16'h0100, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL dec_1 got %h exp %h", obs, e); end
  endtask

  task automatic test_window();
    wrap_en = 1'b1; base = 16'h0010; limit = 16'h0013;
    load(16'h0012);
    arinc = 1'b1;
    tick();
    e = {16'h0013, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_inc1 got %h exp %h", obs, e); end
    tick();
    e = {16'h0010, 4'b0001};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_inc_wrap got %h exp %h", obs, e); end
    tick();
    arinc = 1'b0;
    e = {16'h0011, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_inc3 got %h exp %h", obs, e); end
    ardec = 1'b1;
    tick();
    e = {16'h0010, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_dec1 got %h exp %h", obs, e); end
    tick();
    ardec = 1'b0;
    e = {16'h0013, 4'b0001};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_dec_wrap got %h exp %h", obs, e); end
    load(16'h0013);
    e = {16'h0013, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_load_clears_wrap got %h exp %h", obs, e); end
    load(16'h0020);
    arinc = 1'b1;
    tick();
    arinc = 1'b0;
    e = {16'h0021, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL win_outside got %h exp %h", obs, e); end
    wrap_en = 1'b0;
  endtask

  task automatic test_modulo();
    load(16'h0000);
    ardec = 1'b1;
    tick();
    ardec = 1'b0;
    e = {16'hFFFF, 4'b0001};
    checks++; if (obs !== e) begin errors++; $display("FAIL mod_dec got %h exp %h", obs, e); end
    arinc = 1'b1;
    tick();
    arinc = 1'b0;
    e = {16'h0000, 4'b0001};
    checks++; if (obs !== e) begin errors++; $display("FAIL mod_inc got %h exp %h", obs, e); end
    tick();
    e = {16'h0000, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL mod_pulse_end got %h exp %h", obs, e); end
  endtask

  task automatic test_burst();
    load(16'h0040);
    burst_start = 1'b1; burst_len = 8'd3; arinc = 1'b1;
    tick();
    burst_start = 1'b0;
    e = {16'h0040, 4'b1100};
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_a0 got %h exp %h", obs, e); end
    mem_ack = 1'b1;
    tick();
    e = {16'h0041, 4'b1100};
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_a1 got %h exp %h", obs, e); end
    mem_ack = 1'b0;
    tick();
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_hold got %h exp %h", obs, e); end
    mem_ack = 1'b1;
    tick();
    e = {16'h0042, 4'b1100};
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_a2 got %h exp %h", obs, e); end
    tick();
    mem_ack = 1'b0; arinc = 1'b0; burst_start = 1'b1;
    e = {16'h0043, 4'b0010};
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_done got %h exp %h", obs, e); end
    tick();
    burst_start = 1'b0;
    e = {16'h0043, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_idle got %h exp %h", obs, e); end
    tick();
    checks++; if (obs !== e) begin errors++; $display("FAIL burst_stay_idle got %h exp %h", obs, e); end
  endtask

  task automatic test_abort();
    load(16'h0080);
    burst_start = 1'b1; burst_len = 8'd4;
    tick();
    burst_start = 1'b0; mem_ack = 1'b1;
    tick();
    e = {16'h0081, 4'b1100};
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_step got %h exp %h", obs, e); end
    arload = 1'b1; din = 16'h0200;
    tick();
    arload = 1'b0;
    e = {16'h0200, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_load got %h exp %h", obs, e); end
    tick();
    mem_ack = 1'b0;
    checks++; if (obs !== e) begin errors++; $display("FAIL abort_no_done got %h exp %h", obs, e); end
    burst_start = 1'b1; burst_len = 8'd0;
    tick();
    burst_start = 1'b0;
    checks++; if (obs !== e) begin errors++; $display("FAIL len0_ignored got %h exp %h", obs, e); end
  endtask

  task automatic test_wrap_burst();
    int pulses = 0;
    load(16'hFFFF);
    burst_start = 1'b1; burst_len = 8'd2;
    tick();
    burst_start = 1'b0; mem_ack = 1'b1;
    e = {16'hFFFF, 4'b1100};
    checks++; if (obs !== e) begin errors++; $display("FAIL wb_a0 got %h exp %h", obs, e); end
    tick();
    pulses += int'(wrapped);
    e = {16'h0000, 4'b1101};
    checks++; if (obs !== e) begin errors++; $display("FAIL wb_a1 got %h exp %h", obs, e); end
    tick();
    mem_ack = 1'b0;
    pulses += int'(wrapped);
    e = {16'h0001, 4'b0010};
    checks++; if (obs !== e) begin errors++; $display("FAIL wb_done got %h exp %h", obs, e); end
    tick();
    pulses += int'(wrapped);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL wb_pulses got %0d exp 1", pulses); end
  endtask

  initial begin
    rst = 1'b1; din = '0; base = '0; limit = '0; arload = 1'b0; arinc = 1'b0; ardec = 1'b0;
    wrap_en = 1'b0; burst_start = 1'b0; burst_len = '0; mem_ack = 1'b0;
    #12;
    test_reset();
    rst = 1'b0;
    test_async_reset();
    test_inc_dec();
    test_window();
    test_modulo();
    test_burst();
    test_abort();
    test_wrap_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_gen.md
ADDR_GEN -- requirements
Module: addr_gen

Interface
REQ-001 Parameter AW, default 16, address width in bits.
REQ-002 Parameter LW, default 8, burst length counter width in bits.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high; 1 forces reset state immediately.
REQ-005 din  input  AW  address load value from bus.
REQ-006 arload  input  1  load din into address register.
REQ-007 arinc  input  1  single-step address +1.
REQ-008 ardec  input  1  single-step address -1.
REQ-009 wrap_en  input  1  1 = window wrap between base and limit; 0 = modulo 2^AW.
REQ-010 base  input  AW  window lower bound, inclusive.
REQ-011 limit  input  AW  window upper bound, inclusive; base <= limit required of the driver.
REQ-012 burst_start  input  1  request auto-increment burst.
REQ-013 burst_len  input  LW  number of addresses in burst.
REQ-014 mem_ack  input  1  memory accepted current address.
REQ-015 dout  output  AW  current address to memory/display.
REQ-016 mem_req  output  1  burst address valid, awaiting mem_ack.
REQ-017 burst_busy  output  1  FSM in BURST.
REQ-018 burst_done  output  1  one-cycle pulse on burst completion.
REQ-019 wrapped  output  1  one-cycle pulse on any cycle dout wrapped.

Function
REQ-020 FSM states IDLE, BURST, DONE; all outputs registered.
REQ-021 Priority per cycle: arload > burst step > arinc/ardec.
REQ-022 arload=1 in any state: dout<=din next edge, FSM->IDLE, count cleared, no burst_done; aborts active burst.
REQ-023 IDLE, arinc=1 ardec=0: dout advances +1; arinc=0 ardec=1: dout -1; both 1 or both 0: hold.
REQ-024 Increment with wrap_en=1 and dout==limit: dout<=base, wrapped=1.
REQ-025 Decrement with wrap_en=1 and dout==base: dout<=limit, wrapped=1.
REQ-026 wrap_en=1, dout outside [base,limit]: plain +/-1 modulo 2^AW, no window wrap.
REQ-027 wrap_en=0: arithmetic modulo 2^AW; all-ones+1 -> 0 and 0-1 -> all-ones, each pulsing wrapped=1.
REQ-028 IDLE, burst_start=1, burst_len!=0, arload=0: FSM->BURST, count<=burst_len, mem_req=1, burst_busy=1 from next cycle; arinc/ardec that cycle ignored.
REQ-029 burst_start with burst_len==0 ignored; FSM stays IDLE.
REQ-030 BURST: dout holds while mem_ack=0; each cycle mem_req=1 and mem_ack=1, dout advances +1 per REQ-024/026/027 rules and count decrements.
REQ-031 BURST, mem_ack=1 with count==1: FSM->DONE, mem_req=0, burst_busy=0, dout advanced once more.
REQ-032 DONE: burst_done=1 for exactly one cycle, then IDLE unconditionally; burst_start in DONE ignored.
REQ-033 BURST: arinc, ardec, burst_start ignored.
REQ-034 mem_ack outside BURST ignored.
REQ-035 Burst of N addresses presents dout values A, A+1, ..., A+N-1 (with wrap) on mem_req; after completion dout = address following last one.

Reset
REQ-036 rst=1: dout=0, FSM=IDLE, count=0, mem_req=0, burst_busy=0, burst_done=0, wrapped=0, asynchronously, regardless of clk.
REQ-037 rst asserted mid-burst: burst abandoned, no burst_done pulse; after release FSM in IDLE awaiting new burst_start.
REQ-038 First active edge after rst deassertion processes inputs normally.

Verification
REQ-039 rst pulse mid-cycle with dout=0x1234 -> dout=0x0000, mem_req=0 before next edge.
REQ-040 arload din=0x00FF then arinc 2 cycles, wrap_en=0 -> dout 0x00FF, 0x0100, 0x0101; arinc+ardec together -> holds 0x0101.
REQ-041 wrap_en=1, base=0x0010, limit=0x0013, load 0x0012, arinc 3 cycles -> 0x0013, 0x0010 (wrapped=1 that cycle only), 0x0011; ardec from 0x0010 -> 0x0013, wrapped=1.
REQ-042 load 0x0040, burst_len=3, mem_ack pattern 1,0,1,1 -> mem_req addresses 0x0040, 0x0041, 0x0041, 0x0042; burst_done one cycle; final dout 0x0043; FSM IDLE.
REQ-043 burst_len=4 in BURST after one ack, arload din=0x0200 -> dout=0x0200, mem_req=0, no burst_done; burst_len=0 start -> no mem_req.
REQ-044 wrap_en=0, load 0xFFFF, burst_len=2 with mem_ack=1 -> addresses 0xFFFF, 0x0000, wrapped pulse once, final dout 0x0001.
